// File: rtl/lcd_panel_responder.sv
// Bus-functional responder for a dual-chip KS0108-style graphic LCD bus.
// Two 64x64 chip models with status/data readback and a registered host pixel port.
module lcd_panel_responder #(
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LCD_ENABLE,
  input  logic       LCD_RW,
  input  logic       LCD_DI,
  input  logic       LCD_CS1,
  input  logic       LCD_CS2,
  input  logic       LCD_RST,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  input  logic [9:0] PIX_ADDR,
  output logic [7:0] PIX_DATA,
  output logic [1:0] DISP_ON,
  output logic       ERR_BUSY
);

  localparam int unsigned SyncW = 14;
  // LCD_RST idles high, so its synchronizer resets to 1 to avoid a spurious panel reset.
  localparam logic [SyncW-1:0] SyncRst = 14'h0100;
  localparam logic [3:0] BusyLoad = 4'(BUSY_CYCLES);

  logic [SYNC_STAGES-1:0][SyncW-1:0] sync_q, sync_d;
  logic [SyncW-1:0] sync_s;
  logic             e_s, rw_s, di_s, rst_s;
  logic [1:0]       cs_s;
  logic [7:0]       data_s;
  logic             e_prev_q, e_prev_d;
  logic             commit;

  logic [1:0][5:0] y_q, y_d;
  logic [1:0][2:0] x_q, x_d;
  logic [1:0][5:0] start_q, start_d;
  logic [1:0]      on_q, on_d;
  logic [1:0][7:0] latch_q, latch_d;
  logic [1:0][3:0] busy_q, busy_d;
  logic            rst_flag_q, rst_flag_d;
  logic            err_q, err_d;
  logic [7:0]      pix_data_q, pix_data_d;

  logic [7:0]      mem0 [512];
  logic [7:0]      mem1 [512];
  logic [1:0]      mem_we;
  logic [1:0][8:0] wr_addr;
  logic [1:0][7:0] rd_data;
  logic [1:0][7:0] status;
  logic [1:0][7:0] bus_val;

  always_comb begin
    sync_d[0] = {LCD_ENABLE, LCD_RW, LCD_DI, LCD_CS1, LCD_CS2, LCD_RST, LCD_DATA_IN};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q   <= {SYNC_STAGES{SyncRst}};
      e_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      e_prev_q <= e_prev_d;
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign e_s      = sync_s[13];
  assign rw_s     = sync_s[12];
  assign di_s     = sync_s[11];
  assign cs_s     = {sync_s[9], sync_s[10]};
  assign rst_s    = sync_s[8];
  assign data_s   = sync_s[7:0];
  assign e_prev_d = e_s;
  assign commit   = e_prev_q & ~e_s;

  always_comb begin
    wr_addr[0] = {x_q[0], y_q[0]};
    wr_addr[1] = {x_q[1], y_q[1]};
    rd_data[0] = mem0[wr_addr[0]];
    rd_data[1] = mem1[wr_addr[1]];
  end

  always_comb begin
    y_d        = y_q;
    x_d        = x_q;
    start_d    = start_q;
    on_d       = on_q;
    latch_d    = latch_q;
    busy_d     = busy_q;
    err_d      = err_q;
    mem_we     = 2'b00;
    rst_flag_d = ~rst_s;
    for (int c = 0; c < 2; c++) begin
      busy_d[c] = (busy_q[c] != 4'd0) ? busy_q[c] - 4'd1 : 4'd0;
      if (!rst_s) begin
        y_d[c]     = 6'd0;
        x_d[c]     = 3'd0;
        start_d[c] = 6'd0;
        on_d[c]    = 1'b0;
        busy_d[c]  = 4'd0;
      end else if (commit && cs_s[c] && !(rw_s && !di_s)) begin
        // Status reads never collide; everything else is dropped while busy.
        if (busy_q[c] != 4'd0) begin
          err_d = 1'b1;
        end else if (!rw_s) begin
          busy_d[c] = BusyLoad;
          if (di_s) begin
            mem_we[c] = 1'b1;
            y_d[c]    = y_q[c] + 6'd1;
          end else begin
            case (data_s[7:6])
              2'b01:   y_d[c] = data_s[5:0];
              2'b11:   start_d[c] = data_s[5:0];
              2'b10:   if (data_s[5:3] == 3'b111) x_d[c] = data_s[2:0];
              default: if (data_s[5:1] == 5'b11111) on_d[c] = data_s[0];
            endcase
          end
        end else begin
          latch_d[c] = rd_data[c];
          y_d[c]     = y_q[c] + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      y_q        <= '0;
      x_q        <= '0;
      start_q    <= '0;
      on_q       <= '0;
      latch_q    <= '0;
      busy_q     <= '0;
      rst_flag_q <= 1'b0;
      err_q      <= 1'b0;
      pix_data_q <= 8'h00;
    end else begin
      y_q        <= y_d;
      x_q        <= x_d;
      start_q    <= start_d;
      on_q       <= on_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      rst_flag_q <= rst_flag_d;
      err_q      <= err_d;
      pix_data_q <= pix_data_d;
    end
  end

  // Display RAM is not reset; contents are only defined after the host writes them.
  always_ff @(posedge CLK) begin
    if (mem_we[0]) mem0[wr_addr[0]] <= data_s;
    if (mem_we[1]) mem1[wr_addr[1]] <= data_s;
  end

  assign pix_data_d = PIX_ADDR[9] ? mem1[PIX_ADDR[8:0]] : mem0[PIX_ADDR[8:0]];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      status[c]  = {busy_q[c] != 4'd0, 1'b0, ~on_q[c], rst_flag_q, 4'b0000};
      bus_val[c] = di_s ? latch_q[c] : status[c];
    end
    LCD_DATA_OE  = e_s & rw_s & (|cs_s);
    LCD_DATA_OUT = 8'h00;
    if (LCD_DATA_OE) begin
      LCD_DATA_OUT = cs_s[0] ? bus_val[0] : bus_val[1];
    end
  end

  assign PIX_DATA = pix_data_q;
  assign DISP_ON  = on_q;
  assign ERR_BUSY = err_q;

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Scoreboard bench for lcd_panel_responder: drives KS0108 bus cycles and checks reads,
// pixel readback, display flags and busy errors against a small behavioural panel model.
module tb_lcd_panel_responder;

  logic       clk;
  logic       rst_n;
  logic       lcd_e, lcd_rw, lcd_di, lcd_cs1, lcd_cs2, lcd_rst;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [9:0] pix_addr;
  logic [7:0] pix_data;
  logic [1:0] disp_on;
  logic       err_busy;

  int n_checks;
  int n_pass;

  string      tag_q[$];
  logic [7:0] val_q[$];

  logic [7:0] mram [2][8][64];
  logic [2:0] mx [2];
  logic [5:0] my [2];
  logic       mon [2];
  logic [7:0] mlatch [2];
  logic       model_rst;

  lcd_panel_responder #(
    .BUSY_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .LCD_ENABLE  (lcd_e),
    .LCD_RW      (lcd_rw),
    .LCD_DI      (lcd_di),
    .LCD_CS1     (lcd_cs1),
    .LCD_CS2     (lcd_cs2),
    .LCD_RST     (lcd_rst),
    .LCD_DATA_IN (lcd_data_in),
    .LCD_DATA_OUT(lcd_data_out),
    .LCD_DATA_OE (lcd_data_oe),
    .PIX_ADDR    (pix_addr),
    .PIX_DATA    (pix_data),
    .DISP_ON     (disp_on),
    .ERR_BUSY    (err_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  // hi is the expected bit 8 (bus OE for reads, 0 for pixel reads).
  task automatic sb_pop_check(input logic [15:0] obs, input logic hi);
    string      tag;
    logic [7:0] val;
    if (val_q.size() != 0) begin
      tag = tag_q.pop_front();
      val = val_q.pop_front();
      check_eq(tag, obs, {7'b0, hi, val});
    end
  endtask

  function automatic void model_commit(input logic rw, input logic di, input logic c1,
                                       input logic c2, input logic [7:0] d);
    logic [1:0] sel;
    sel = {c2, c1};
    if (model_rst) return;
    for (int c = 0; c < 2; c++) begin
      if (sel[c]) begin
        if (!rw && di) begin
          mram[c][mx[c]][my[c]] = d;
          my[c] = my[c] + 6'd1;
        end else if (!rw) begin
          if (d[7:6] == 2'b01) my[c] = d[5:0];
          else if (d[7:3] == 5'b10111) mx[c] = d[2:0];
          else if (d[7:1] == 7'b0011111) mon[c] = d[0];
        end else if (di) begin
          mlatch[c] = mram[c][mx[c]][my[c]];
          my[c] = my[c] + 6'd1;
        end
      end
    end
  endfunction

  // Normal cycle: E high 3 clocks (read sampled at the end), then 3 clocks of hold so the
  // commit has landed on return. Fast cycle: E high 1 clock, 1 clock of hold.
  task automatic xfer(input logic rw, input logic di, input logic c1, input logic c2,
                      input logic [7:0] d, input logic fast, input logic chk);
    lcd_rw = rw;
    lcd_di = di;
    lcd_cs1 = c1;
    lcd_cs2 = c2;
    lcd_data_in = d;
    lcd_e = 1'b1;
    @(posedge clk); #1;
    if (!fast) begin
      repeat (2) begin @(posedge clk); #1; end
      if (chk) sb_pop_check({7'b0, lcd_data_oe, lcd_data_out}, 1'b1);
    end
    lcd_e = 1'b0;
    repeat (fast ? 1 : 3) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic c1, input logic c2, input logic di, input logic [7:0] d);
    xfer(1'b0, di, c1, c2, d, 1'b0, 1'b0);
    model_commit(1'b0, di, c1, c2, d);
  endtask

  task automatic rd_status(input logic c1, input logic c2, input logic [7:0] exp,
                           input string tag);
    sb_push(tag, exp);
    xfer(1'b1, 1'b0, c1, c2, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic rd_data(input logic c1, input logic c2, input logic chk, input string tag);
    if (chk) sb_push(tag, c1 ? mlatch[0] : mlatch[1]);
    xfer(1'b1, 1'b1, c1, c2, 8'h00, 1'b0, chk);
    model_commit(1'b1, 1'b1, c1, c2, 8'h00);
  endtask

  task automatic pix_check(input logic [9:0] a, input string tag);
    sb_push(tag, mram[a[9]][a[8:6]][a[5:0]]);
    pix_addr = a;
    @(posedge clk); #1;
    sb_pop_check({8'h00, pix_data}, 1'b0);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    lcd_e = 1'b0;
    lcd_rw = 1'b0;
    lcd_di = 1'b0;
    lcd_cs1 = 1'b0;
    lcd_cs2 = 1'b0;
    lcd_rst = 1'b1;
    lcd_data_in = 8'h00;
    pix_addr = 10'h000;
    n_checks = 0;
    n_pass = 0;
    model_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mx[c] = 3'd0;
      my[c] = 6'd0;
      mon[c] = 1'b0;
      mlatch[c] = 8'h00;
      for (int p = 0; p < 8; p++)
        for (int y = 0; y < 64; y++) mram[c][p][y] = 8'h00;
    end

    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_data_out", {8'h00, lcd_data_out}, 16'h0000);
    check_eq("rst_data_oe", {15'h0, lcd_data_oe}, 16'h0000);
    check_eq("rst_pix_data", {8'h00, pix_data}, 16'h0000);
    check_eq("rst_disp_on", {14'h0, disp_on}, 16'h0000);
    check_eq("rst_err_busy", {15'h0, err_busy}, 16'h0000);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Clear both chips' RAM at once through the bus.
    for (int p = 0; p < 8; p++) begin
      wr(1'b1, 1'b1, 1'b0, {5'b10111, 3'(p)});
      wr(1'b1, 1'b1, 1'b0, 8'h40);
      for (int y = 0; y < 64; y++) wr(1'b1, 1'b1, 1'b1, 8'h00);
    end
    check_eq("clear_no_err", {15'h0, err_busy}, 16'h0000);

    wr(1'b1, 1'b1, 1'b0, 8'h3F);
    check_eq("disp_on_both", {14'h0, disp_on}, {14'h0, mon[1], mon[0]});
    wr(1'b1, 1'b0, 1'b0, 8'h3E);
    check_eq("disp_off_cs1", {14'h0, disp_on}, {14'h0, mon[1], mon[0]});

    wr(1'b1, 1'b0, 1'b0, 8'hBB);
    wr(1'b1, 1'b0, 1'b0, 8'h40);
    wr(1'b1, 1'b0, 1'b1, 8'hF8);
    wr(1'b1, 1'b0, 1'b1, 8'h08);
    pix_check(10'h0C0, "pix_0c0");
    pix_check(10'h0C1, "pix_0c1");

    wr(1'b0, 1'b1, 1'b0, 8'hBD);
    wr(1'b0, 1'b1, 1'b0, 8'h7F);
    wr(1'b0, 1'b1, 1'b1, 8'h11);
    wr(1'b0, 1'b1, 1'b1, 8'h22);
    wr(1'b0, 1'b1, 1'b1, 8'h33);
    pix_check(10'h37F, "pix_wrap_63");
    pix_check(10'h340, "pix_wrap_0");
    pix_check(10'h341, "pix_wrap_1");
    pix_check(10'h33F, "pix_prev_page");

    // Preload the output latch with a known byte, then the dummy-read sequence.
    wr(1'b1, 1'b0, 1'b0, 8'hBB);
    wr(1'b1, 1'b0, 1'b0, 8'h41);
    rd_data(1'b1, 1'b0, 1'b0, "rd_preload");
    wr(1'b1, 1'b0, 1'b0, 8'hBB);
    wr(1'b1, 1'b0, 1'b0, 8'h40);
    rd_data(1'b1, 1'b0, 1'b1, "rd_stale");
    rd_data(1'b1, 1'b0, 1'b1, "rd_f8");
    wr(1'b1, 1'b0, 1'b1, 8'h5A);
    pix_check(10'h0C2, "pix_y_after_reads");

    wr(1'b0, 1'b1, 1'b0, 8'h40);
    rd_status(1'b0, 1'b1, 8'h80, "status_busy_on");
    wr(1'b1, 1'b0, 1'b0, 8'h40);
    rd_status(1'b1, 1'b0, 8'hA0, "status_busy_off");

    // Second fast write commits inside the busy window of the first and must be dropped.
    xfer(1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 1'b1, 1'b0);
    model_commit(1'b0, 1'b0, 1'b1, 1'b0, 8'h4A);
    xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    check_eq("err_busy_set", {15'h0, err_busy}, 16'h0001);
    pix_check(10'h0CA, "pix_dropped");
    wr(1'b1, 1'b0, 1'b1, 8'h66);
    pix_check(10'h0CA, "pix_after_drop");

    lcd_rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mx[c] = 3'd0;
      my[c] = 6'd0;
      mon[c] = 1'b0;
    end
    model_rst = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    rd_status(1'b1, 1'b0, 8'h30, "status_lcdrst_cs1");
    rd_status(1'b0, 1'b1, 8'h30, "status_lcdrst_cs2");
    check_eq("lcdrst_disp", {14'h0, disp_on}, 16'h0000);
    wr(1'b1, 1'b0, 1'b1, 8'h99);
    wr(1'b1, 1'b1, 1'b0, 8'h3F);
    check_eq("lcdrst_disp_ignored", {14'h0, disp_on}, 16'h0000);
    pix_check(10'h0C0, "lcdrst_pix_0c0");
    pix_check(10'h37F, "lcdrst_pix_37f");
    pix_check(10'h000, "lcdrst_pix_000");
    check_eq("lcdrst_err_kept", {15'h0, err_busy}, 16'h0001);

    lcd_rst = 1'b1;
    model_rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rd_status(1'b1, 1'b0, 8'h20, "status_after_lcdrst");
    wr(1'b1, 1'b0, 1'b1, 8'hC3);
    pix_check(10'h000, "pix_after_lcdrst");

    check_eq("sb_drained", 16'(val_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
